dma_controller: RTL and testbench

- Two-channel DMA engine that moves 32-bit words between I/O devices and the shared RAM (64 words, 6-bit address).
- It owns the bus-arbitration side of the processor's hold handshake. It raises holdReq, waits for holdAck, then drives the RAM address, data and control lines directly. It drives hReady low while it holds the bus.
- Channels are programmed through a small config port and burst while their device request stays high.

---
 rtl/dma_controller.sv | 209 ++++++++++++++++++++
 tb/tb_dma_controller.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_controller.sv
// Two-channel DMA engine. It requests the bus through a hold handshake and
// moves one 32-bit word per cycle between a device and the shared RAM.
// Channel 0 has fixed priority over channel 1. All outputs are registered.
module dma_controller #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfgWe,
  input  logic              cfgCh,
  input  logic [ADDR_W-1:0] cfgAddr,
  input  logic [CNT_W-1:0]  cfgCount,
  input  logic              cfgDir,
  input  logic [1:0]        dreq,
  output logic [1:0]        dack,
  output logic              holdReq,
  input  logic              holdAck,
  output logic              hReady,
  output logic [ADDR_W-1:0] ramAddress,
  output logic              ramEn,
  output logic              ramCtrl,
  output logic [DATA_W-1:0] ramWrData,
  input  logic [DATA_W-1:0] ramRdData,
  input  logic [DATA_W-1:0] ioDataIn,
  output logic [DATA_W-1:0] ioDataOut,
  output logic              ioValid,
  output logic [1:0]        tc,
  output logic              cfgBusy
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE} state_t;

  state_t state_reg, state_next;
  logic   active_reg, active_next;

  // Per-channel views gathered from the channel generate blocks
  logic [ADDR_W-1:0] addr_vec [2];
  logic [CNT_W-1:0]  count_vec [2];
  logic [1:0]        dir_vec;
  logic [1:0]        ready;
  logic [1:0]        cfg_accept;

  // Control decisions for the coming edge
  logic beat;
  logic finish_tc;
  logic hold_req_next;
  logic h_ready_next;
  logic cfg_busy_next;

  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0]  cur_count;
  logic              cur_dir;
  logic              cur_ready;
  logic              cur_dreq;
  logic [1:0]        active_onehot;

  assign cur_addr      = addr_vec[active_reg];
  assign cur_count     = count_vec[active_reg];
  assign cur_dir       = dir_vec[active_reg];
  assign cur_ready     = ready[active_reg];
  assign cur_dreq      = dreq[active_reg];
  assign active_onehot = active_reg ? 2'b10 : 2'b01;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic [ADDR_W-1:0] addr_reg;
      logic [CNT_W-1:0]  count_reg;
      logic              dir_reg;
      logic              is_active;

      assign is_active = (active_reg == 1'(gi));
      // The active channel is locked against reprogramming until back in IDLE;
      // this also covers a write landing on the same edge as its tc.
      assign cfg_accept[gi] = cfgWe && (cfgCh == 1'(gi)) &&
                              !(is_active && (state_reg != IDLE));
      assign ready[gi]      = dreq[gi] && (count_reg != '0);
      assign addr_vec[gi]   = addr_reg;
      assign count_vec[gi]  = count_reg;
      assign dir_vec[gi]    = dir_reg;

      // Channel registers: load on config, advance on each beat of this channel
      always_ff @(posedge clk) begin
        if (rst) begin
          addr_reg  <= '0;
          count_reg <= '0;
          dir_reg   <= 1'b0;
        end else if (cfg_accept[gi]) begin
          addr_reg  <= cfgAddr;
          count_reg <= cfgCount;
          dir_reg   <= cfgDir;
        end else if (beat && is_active) begin
          addr_reg  <= addr_reg + ADDR_W'(1);
          count_reg <= count_reg - CNT_W'(1);
        end
      end
    end
  endgenerate

  // State and active-channel registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      active_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      active_reg <= active_next;
    end
  end

  // Next-state logic and next values of the handshake outputs
  always_comb begin
    state_next    = state_reg;
    active_next   = active_reg;
    beat          = 1'b0;
    finish_tc     = 1'b0;
    hold_req_next = holdReq;
    h_ready_next  = hReady;
    cfg_busy_next = cfgBusy;
    case (state_reg)
      IDLE: begin
        // holdAck must have been withdrawn before a new request is raised
        if ((ready != 2'b00) && !holdAck) begin
          active_next   = ready[0] ? 1'b0 : 1'b1;
          hold_req_next = 1'b1;
          cfg_busy_next = 1'b1;
          state_next    = REQ;
        end
      end
      REQ: begin
        if (!cur_ready) begin
          hold_req_next = 1'b0;
          h_ready_next  = 1'b1;
          cfg_busy_next = 1'b0;
          state_next    = RELEASE;
        end else if (holdAck) begin
          h_ready_next = 1'b0;
          state_next   = XFER;
        end
      end
      XFER: begin
        // A zero count here means the last beat just completed
        if (cur_count == '0) begin
          finish_tc     = 1'b1;
          hold_req_next = 1'b0;
          h_ready_next  = 1'b1;
          cfg_busy_next = 1'b0;
          state_next    = RELEASE;
        end else if (!cur_dreq) begin
          hold_req_next = 1'b0;
          h_ready_next  = 1'b1;
          cfg_busy_next = 1'b0;
          state_next    = RELEASE;
        end else if (!holdAck) begin
          // Grant lost: keep the bus claimed and wait for it to return
          state_next = REQ;
        end else begin
          beat = 1'b1;
        end
      end
      RELEASE: begin
        hold_req_next = 1'b0;
        h_ready_next  = 1'b1;
        cfg_busy_next = 1'b0;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered bus, device and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      holdReq    <= 1'b0;
      hReady     <= 1'b1;
      cfgBusy    <= 1'b0;
      ramEn      <= 1'b0;
      dack       <= 2'b00;
      tc         <= 2'b00;
      ramAddress <= '0;
      ramCtrl    <= 1'b0;
      ramWrData  <= '0;
      ioDataOut  <= '0;
      ioValid    <= 1'b0;
    end else begin
      holdReq <= hold_req_next;
      hReady  <= h_ready_next;
      cfgBusy <= cfg_busy_next;
      ramEn   <= beat;
      dack    <= beat ? active_onehot : 2'b00;
      tc      <= finish_tc ? active_onehot : 2'b00;
      if (beat) begin
        ramAddress <= cur_addr;
        ramCtrl    <= ~cur_dir;
        if (!cur_dir) begin
          ramWrData <= ioDataIn;
        end
      end
      // A read beat's data is captured at the end of that beat
      ioValid <= ramEn && !ramCtrl;
      if (ramEn && !ramCtrl) begin
        ioDataOut <= ramRdData;
      end
    end
  end

endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller: a transaction-level model predicts
// every beat (channel, address, direction, data) and the tc / ioValid pulses
// that follow; literal tables pin the model for each scenario.
module tb_dma_controller;

  logic        clk;
  logic        rst;
  logic        cfgWe;
  logic        cfgCh;
  logic [5:0]  cfgAddr;
  logic [7:0]  cfgCount;
  logic        cfgDir;
  logic [1:0]  dreq;
  logic [1:0]  dack;
  logic        holdReq;
  logic        holdAck;
  logic        hReady;
  logic [5:0]  ramAddress;
  logic        ramEn;
  logic        ramCtrl;
  logic [31:0] ramWrData;
  logic [31:0] ramRdData;
  logic [31:0] ioDataIn;
  logic [31:0] ioDataOut;
  logic        ioValid;
  logic [1:0]  tc;
  logic        cfgBusy;

  logic [31:0] ram [64];
  assign ramRdData = ram[ramAddress];

  dma_controller #(.ADDR_W(6), .DATA_W(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfgWe(cfgWe), .cfgCh(cfgCh), .cfgAddr(cfgAddr),
    .cfgCount(cfgCount), .cfgDir(cfgDir), .dreq(dreq), .dack(dack),
    .holdReq(holdReq), .holdAck(holdAck), .hReady(hReady),
    .ramAddress(ramAddress), .ramEn(ramEn), .ramCtrl(ramCtrl),
    .ramWrData(ramWrData), .ramRdData(ramRdData), .ioDataIn(ioDataIn),
    .ioDataOut(ioDataOut), .ioValid(ioValid), .tc(tc), .cfgBusy(cfgBusy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int compared   = 0;
  int mismatched = 0;

  // Model state
  int          mdl_addr [2];
  int          mdl_count [2];
  bit          mdl_dir [2];
  int          dev_n;
  logic [1:0]  tc_pend;
  bit          rd_pend;
  logic [31:0] rd_data;
  int          tc_seen [2];
  int          log_addr [$];
  int          log_ch [$];
  logic [31:0] log_rd [$];
  bit          gap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Processor side of the hold handshake: grants one half cycle after request
  initial begin
    holdAck = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      holdAck = holdReq && !gap;
    end
  end

  // Compare process: checks every cycle against the transaction model
  initial begin
    dev_n    = 0;
    ioDataIn = 32'hA0;
    tc_pend  = 2'b00;
    rd_pend  = 1'b0;
    rd_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        chk("rst_ctrl", {22'd0, holdReq, hReady, ramEn, ioValid, cfgBusy, ramCtrl, dack, tc}, 32'h100);
        chk("rst_addr", {26'd0, ramAddress}, 32'd0);
        chk("rst_wdata", ramWrData, 32'd0);
        chk("rst_iodata", ioDataOut, 32'd0);
        tc_pend = 2'b00;
        rd_pend = 1'b0;
      end else begin
        chk("tc", {30'd0, tc}, {30'd0, tc_pend});
        chk("io_valid", {31'd0, ioValid}, {31'd0, rd_pend});
        if (rd_pend) chk("io_data_out", ioDataOut, rd_data);
        if (ioValid) log_rd.push_back(ioDataOut);
        if (tc[0]) tc_seen[0]++;
        if (tc[1]) tc_seen[1]++;
        tc_pend = 2'b00;
        rd_pend = 1'b0;
        if (ramEn) begin
          int ch;
          ch = dack[1] ? 1 : 0;
          chk("dack_beat", {30'd0, dack}, (ch == 1) ? 32'd2 : 32'd1);
          chk("bus_owned", {29'd0, holdReq, hReady, holdAck}, 32'b101);
          chk("ram_addr", {26'd0, ramAddress}, mdl_addr[ch]);
          chk("ram_ctrl", {31'd0, ramCtrl}, {31'd0, !mdl_dir[ch]});
          if (!mdl_dir[ch]) begin
            chk("ram_wr_data", ramWrData, 32'hA0 + dev_n);
            ram[ramAddress] = ramWrData;
            dev_n++;
            ioDataIn = 32'hA0 + dev_n;
          end else begin
            rd_pend = 1'b1;
            rd_data = ram[mdl_addr[ch]];
          end
          log_addr.push_back(mdl_addr[ch]);
          log_ch.push_back(ch);
          mdl_addr[ch]  = (mdl_addr[ch] + 1) % 64;
          mdl_count[ch] = (mdl_count[ch] - 1) & 255;
          if (mdl_count[ch] == 0) tc_pend = (ch == 1) ? 2'b10 : 2'b01;
        end else begin
          chk("dack_idle", {30'd0, dack}, 32'd0);
        end
      end
    end
  end

  task automatic cfg(input logic ch, input logic [5:0] a, input logic [7:0] c,
                     input logic d, input bit accept);
    @(negedge clk);
    cfgWe = 1'b1; cfgCh = ch; cfgAddr = a; cfgCount = c; cfgDir = d;
    @(posedge clk);
    if (accept) begin
      mdl_addr[ch]  = a;
      mdl_count[ch] = c;
      mdl_dir[ch]   = d;
    end
    @(negedge clk);
    cfgWe = 1'b0;
  endtask

  task automatic clear_logs();
    log_addr.delete();
    log_ch.delete();
    log_rd.delete();
    tc_seen[0] = 0;
    tc_seen[1] = 0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_beats(input int n, input string name);
    for (int i = 0; i < 40 && log_addr.size() < n; i++) @(negedge clk);
    chk(name, log_addr.size(), n);
  endtask

  task automatic check_idle(input string name);
    chk(name, {29'd0, holdReq, hReady, cfgBusy}, 32'b010);
  endtask

  task automatic check_addrs(input string name, input int exp [$]);
    chk({name, "_n"}, log_addr.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log_addr.size(); i++)
      chk(name, log_addr[i], exp[i]);
  endtask

  initial begin
    int exp_a [$];
    int exp_c [$];
    rst = 1'b1; cfgWe = 1'b0; cfgCh = 1'b0; cfgAddr = '0; cfgCount = '0;
    cfgDir = 1'b0; dreq = 2'b11; gap = 1'b0;
    for (int i = 0; i < 64; i++) ram[i] = 32'hC0DE_0000 + i;
    for (int i = 0; i < 2; i++) begin
      mdl_addr[i] = 0; mdl_count[i] = 0; mdl_dir[i] = 1'b0; tc_seen[i] = 0;
    end

    // Reset with requests pending: nothing may start afterwards (counts are 0)
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_hold", {30'd0, holdReq, hReady}, 32'b01);
    chk("reset_dack_tc", {28'd0, dack, tc}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_req_after_reset", {31'd0, holdReq}, 32'd0);
    end
    dreq = 2'b00;

    // I/O -> RAM, ch0 at 0x05 for 3 words
    clear_logs();
    cfg(1'b0, 6'h05, 8'd3, 1'b0, 1'b1);
    dreq = 2'b01;
    run(12);
    dreq = 2'b00;
    exp_a = '{5, 6, 7};
    check_addrs("t_wr_addr", exp_a);
    chk("t_wr_tc0", tc_seen[0], 1);
    chk("t_wr_ram5", ram[5], 32'hA0);
    chk("t_wr_ram6", ram[6], 32'hA1);
    chk("t_wr_ram7", ram[7], 32'hA2);
    check_idle("t_wr_idle");

    // RAM -> I/O with address wrap, ch1 at 0x3E
    clear_logs();
    cfg(1'b1, 6'h3E, 8'd3, 1'b1, 1'b1);
    dreq = 2'b10;
    run(12);
    dreq = 2'b00;
    exp_a = '{62, 63, 0};
    check_addrs("t_rd_addr", exp_a);
    chk("t_rd_tc1", tc_seen[1], 1);
    chk("t_rd_n", log_rd.size(), 3);
    if (log_rd.size() == 3) begin
      chk("t_rd_d0", log_rd[0], 32'hC0DE_003E);
      chk("t_rd_d1", log_rd[1], 32'hC0DE_003F);
      chk("t_rd_d2", log_rd[2], 32'hC0DE_0000);
    end
    check_idle("t_rd_idle");

    // Priority: both ready, ch0 finishes before ch1 is served
    clear_logs();
    cfg(1'b0, 6'h10, 8'd2, 1'b0, 1'b1);
    cfg(1'b1, 6'h20, 8'd2, 1'b0, 1'b1);
    dreq = 2'b11;
    run(20);
    dreq = 2'b00;
    exp_a = '{16, 17, 32, 33};
    check_addrs("t_pri_addr", exp_a);
    exp_c = '{0, 0, 1, 1};
    for (int i = 0; i < 4 && i < log_ch.size(); i++) chk("t_pri_ch", log_ch[i], exp_c[i]);
    chk("t_pri_tc", {tc_seen[1][15:0], tc_seen[0][15:0]}, 32'h0001_0001);
    check_idle("t_pri_idle");

    // Pause after 2 beats, then resume the remaining 2
    clear_logs();
    cfg(1'b0, 6'h0A, 8'd4, 1'b0, 1'b1);
    dreq = 2'b01;
    wait_beats(2, "t_pause_wait");
    dreq = 2'b00;
    run(6);
    chk("t_pause_n", log_addr.size(), 2);
    chk("t_pause_no_tc", tc_seen[0], 0);
    check_idle("t_pause_idle");
    dreq = 2'b01;
    run(12);
    dreq = 2'b00;
    exp_a = '{10, 11, 12, 13};
    check_addrs("t_resume_addr", exp_a);
    chk("t_resume_tc", tc_seen[0], 1);

    // Grant loss for 2 cycles mid-burst, with a locked-out config write
    clear_logs();
    cfg(1'b1, 6'h30, 8'd5, 1'b0, 1'b1);
    dreq = 2'b10;
    wait_beats(1, "t_gap_wait");
    gap = 1'b1;
    cfg(1'b1, 6'h00, 8'd1, 1'b1, 1'b0);
    chk("t_gap_nobeat", log_addr.size(), 1);
    chk("t_gap_hold", {30'd0, holdReq, hReady}, 32'b10);
    gap = 1'b0;
    run(15);
    dreq = 2'b00;
    exp_a = '{48, 49, 50, 51, 52};
    check_addrs("t_gap_addr", exp_a);
    chk("t_gap_tc", tc_seen[1], 1);
    check_idle("t_gap_idle");

    // Reset mid-transfer: burst abandoned without tc
    clear_logs();
    cfg(1'b0, 6'h02, 8'd5, 1'b0, 1'b1);
    dreq = 2'b01;
    wait_beats(1, "t_rst_wait");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mdl_addr[i] = 0; mdl_count[i] = 0; mdl_dir[i] = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t_rst_no_req", {31'd0, holdReq}, 32'd0);
    end
    dreq = 2'b00;
    chk("t_rst_beats", log_addr.size(), 1);
    chk("t_rst_no_tc", tc_seen[0], 0);
    check_idle("t_rst_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
